// File: rtl/imem_port_arbiter_pkg.sv
// Shared types and helpers for the instruction-memory port arbiter.
package imem_pkg;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/imem_port_arbiter_if.sv
// Fetch, loader and RAM-side signals of the instruction-memory arbiter.
// IMEM_BOUNDS_CHECK_EN adds the f_fault signal.
interface imem_port_arbiter_if
  import imem_pkg::*;
#(
  parameter int ADDRESS = 32,
  parameter int DATA    = 32,
  parameter int DEPTH   = 64
);
  localparam int IDX_W = clog2(DEPTH);

  logic               f_req;
  logic [ADDRESS-1:0] f_addr;
  logic               f_gnt;
  logic               f_rvalid;
  logic [DATA-1:0]    f_rdata;
`ifdef IMEM_BOUNDS_CHECK_EN
  logic               f_fault;
`endif
  logic               ld_req;
  logic [ADDRESS-1:0] ld_addr;
  logic [DATA-1:0]    ld_wdata;
  logic               ld_gnt;
  logic               ld_done;
  logic               core_stall;
  logic               mem_en;
  logic               mem_we;
  logic [IDX_W-1:0]   mem_addr;
  logic [DATA-1:0]    mem_wdata;
  logic [DATA-1:0]    mem_rdata;

  modport slave (
`ifdef IMEM_BOUNDS_CHECK_EN
    output f_fault,
`endif
    input  f_req, f_addr, ld_req, ld_addr, ld_wdata, ld_done, mem_rdata,
    output f_gnt, f_rvalid, f_rdata, ld_gnt, core_stall,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
`ifdef IMEM_BOUNDS_CHECK_EN
    input  f_fault,
`endif
    output f_req, f_addr, ld_req, ld_addr, ld_wdata, ld_done, mem_rdata,
    input  f_gnt, f_rvalid, f_rdata, ld_gnt, core_stall,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/imem_port_arbiter_starve_ctr.sv
// Saturating count of consecutive loader losses; sat flags a forced loader grant.
module imem_starve_ctr
  import imem_pkg::*;
#(
  parameter int LIM = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic sat
);
  localparam int W = (clog2(LIM + 1) < 1) ? 1 : clog2(LIM + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != W'(LIM))) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign sat = (cnt == W'(LIM));

endmodule

// File: rtl/imem_port_arbiter.sv
// Arbitrates a single-ported synchronous-read instruction RAM between fetch and loader.
// Optional IMEM_BOUNDS_CHECK_EN: misaligned/out-of-range requests complete without RAM access.
module imem_port_arbiter
  import imem_pkg::*;
#(
  parameter int ADDRESS    = 32,
  parameter int DATA       = 32,
  parameter int DEPTH      = 64,
  parameter int STARVE_LIM = 4
) (
  input  logic                clk,
  input  logic                reset,
  imem_port_arbiter_if.slave  bus
);
  localparam int IDX_W = clog2(DEPTH);

  state_t            state, state_next;
  logic              f_win, ld_win, stall;
  logic              starve_sat;
  logic              f_bad, ld_bad;
  logic [IDX_W-1:0]  f_idx, ld_idx;
  logic              rvalid_q, fault_q;
  logic [DATA-1:0]   rdata_q;
  logic [DATA-1:0]   rdata_now;

  assign f_idx  = bus.f_addr[IDX_W+1:2];
  assign ld_idx = bus.ld_addr[IDX_W+1:2];

`ifdef IMEM_BOUNDS_CHECK_EN
  assign f_bad  = (|bus.f_addr[1:0])  || (|bus.f_addr[ADDRESS-1:IDX_W+2]);
  assign ld_bad = (|bus.ld_addr[1:0]) || (|bus.ld_addr[ADDRESS-1:IDX_W+2]);
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.f_addr[1:0], bus.f_addr[ADDRESS-1:IDX_W+2],
                              bus.ld_addr[1:0], bus.ld_addr[ADDRESS-1:IDX_W+2]};
  assign f_bad  = 1'b0;
  assign ld_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= ST_BOOT;
    else       state <= state_next;
  end

  // Reset suppresses every grant so no RAM access is issued in a reset cycle.
  always_comb begin
    state_next = state;
    f_win      = 1'b0;
    ld_win     = 1'b0;
    stall      = 1'b1;
    if (!reset) begin
      case (state)
        ST_BOOT: begin
          ld_win = bus.ld_req;
          if (bus.ld_done && !bus.ld_req) state_next = ST_RUN;
        end
        ST_RUN: begin
          f_win  = bus.f_req && !(starve_sat && bus.ld_req);
          ld_win = bus.ld_req && !f_win;
          stall  = bus.f_req && !f_win;
        end
        default: state_next = ST_BOOT;
      endcase
    end
  end

  imem_starve_ctr #(.LIM(STARVE_LIM)) u_starve (
    .clk   (clk),
    .reset (reset),
    .clr   (ld_win || !bus.ld_req),
    .inc   (bus.ld_req && !ld_win),
    .sat   (starve_sat)
  );

  assign bus.f_gnt      = f_win;
  assign bus.ld_gnt     = ld_win;
  assign bus.core_stall = stall;
  assign bus.mem_en     = (f_win && !f_bad) || (ld_win && !ld_bad);
  assign bus.mem_we     = ld_win && !ld_bad;
  assign bus.mem_addr   = ld_win ? ld_idx : (f_win ? f_idx : '0);
  assign bus.mem_wdata  = ld_win ? bus.ld_wdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid_q <= 1'b0;
      fault_q  <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= f_win;
      fault_q  <= f_win && f_bad;
      if (rvalid_q) rdata_q <= rdata_now;
    end
  end

  // Read data is forwarded straight from the RAM in the valid cycle and held afterwards.
  assign rdata_now    = fault_q ? DATA'(NOP_INSTR) : bus.mem_rdata;
  assign bus.f_rvalid = rvalid_q && !reset;
  assign bus.f_rdata  = reset ? '0 : (rvalid_q ? rdata_now : rdata_q);
`ifdef IMEM_BOUNDS_CHECK_EN
  assign bus.f_fault  = rvalid_q && fault_q && !reset;
`endif

endmodule
